// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants, sync positions and polarity encoding
package vga_timing_pkg;
    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;
    typedef logic [CNT_W-1:0] coord_t;
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;
    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_H_TOTAL      = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL      = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;
    // true when lo <= c < hi
    function automatic logic in_window(input coord_t c, input int lo, input int hi);
        return int'(c) >= lo && int'(c) < hi;
    endfunction
endpackage

// File: rtl/vga_sync_if.sv
// vga_sync_if: timing outputs from the sync generator to the pixel/frame-buffer consumers
interface vga_sync_if import vga_timing_pkg::*; ();
    coord_t pixel_x;
    coord_t pixel_y;
    logic   h_video_on;
    logic   v_video_on;
    logic   hsync;
    logic   vsync;
    logic   pixel_tick;
    logic   line_start;
    logic   frame_start;
    modport master (output pixel_x, pixel_y, h_video_on, v_video_on, hsync, vsync,
                    pixel_tick, line_start, frame_start);
    modport slave  (input  pixel_x, pixel_y, h_video_on, v_video_on, hsync, vsync,
                    pixel_tick, line_start, frame_start);
endinterface

// File: rtl/vga_sync_pixel_tick_gen.sv
// pixel_tick_gen: divides clk by CLK_DIV, adv is high in the last clock of each pixel period
module pixel_tick_gen import vga_timing_pkg::*; #(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic adv
);
    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt_q, div_cnt_d;

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pixel_tick_gen: CLK_DIV must be at least 1");
    end

    // wrap the divider on the advance clock
    always_comb begin
        adv       = div_cnt_q == LAST;
        div_cnt_d = adv ? '0 : div_cnt_q + 1'b1;
    end

    // divider register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt_q <= '0;
        else        div_cnt_q <= div_cnt_d;
    end
endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA horizontal/vertical timing generator with registered, mutually aligned outputs
module vga_sync import vga_timing_pkg::*; #(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = SYNC_ACTIVE_LOW
) (
    input  logic       clk,
    input  logic       rst_n,
    vga_sync_if.master vga
);
    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_totals
        $error("vga_sync: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end

    logic   adv, h_wrap, v_wrap;
    coord_t x_q, x_d, y_q, y_d;
    logic   h_video_on_q, h_video_on_d, v_video_on_q, v_video_on_d;
    logic   hsync_q, hsync_d, vsync_q, vsync_d;
    logic   pixel_tick_q, pixel_tick_d, line_start_q, line_start_d;
    logic   frame_start_q, frame_start_d;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv)
    );

    // next counters, and decodes taken from the next counters so outputs stay aligned
    always_comb begin
        h_wrap        = x_q == H_LAST;
        v_wrap        = y_q == V_LAST;
        x_d           = adv ? (h_wrap ? '0 : x_q + 1'b1) : x_q;
        y_d           = (adv && h_wrap) ? (v_wrap ? '0 : y_q + 1'b1) : y_q;
        h_video_on_d  = int'(x_d) < H_DISPLAY;
        v_video_on_d  = int'(y_d) < V_DISPLAY;
        hsync_d       = in_window(x_d, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = in_window(y_d, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        pixel_tick_d  = adv;
        line_start_d  = adv && h_wrap;
        frame_start_d = adv && h_wrap && v_wrap;
    end

    // output/state registers; reset lands on pixel (0,0) with syncs inactive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            h_video_on_q  <= 1'b1;
            v_video_on_q  <= 1'b1;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            pixel_tick_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            h_video_on_q  <= h_video_on_d;
            v_video_on_q  <= v_video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pixel_tick_q  <= pixel_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pixel_x     = x_q;
    assign vga.pixel_y     = y_q;
    assign vga.h_video_on  = h_video_on_q;
    assign vga.v_video_on  = v_video_on_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.pixel_tick  = pixel_tick_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed vectors for the default 640x480 timing and a tiny CLK_DIV=1 configuration
module tb_vga_sync;
    import vga_timing_pkg::*;

    typedef struct {
        int         n;
        int         x;
        int         y;
        logic [6:0] f;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a_n, rst_b_n;
    int   checks = 0, errors = 0;
    int   cyc = 0, fs_a = 0, fs_b = 0;
    vec_t va[13];
    vec_t vb[14];

    always #5 clk = ~clk;

    vga_sync_if ia ();
    vga_sync_if ib ();

    vga_sync dut_a (.clk(clk), .rst_n(rst_a_n), .vga(ia));

    vga_sync #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_b (.clk(clk), .rst_n(rst_b_n), .vga(ib));

    function automatic logic [6:0] flags_a();
        return {ia.h_video_on, ia.v_video_on, ia.hsync, ia.vsync, ia.pixel_tick, ia.line_start, ia.frame_start};
    endfunction

    function automatic logic [6:0] flags_b();
        return {ib.h_video_on, ib.v_video_on, ib.hsync, ib.vsync, ib.pixel_tick, ib.line_start, ib.frame_start};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v, input int x, input int y, input logic [6:0] f);
        checks++;
        if (x != v.x || y != v.y || f !== v.f) begin
            errors++;
            $display("FAIL %s n=%0d: got x=%0d y=%0d flags(hv,vv,hs,vs,pt,ls,fs)=%b expected x=%0d y=%0d flags=%b",
                     tag, v.n, x, y, f, v.x, v.y, v.f);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        fs_a += int'(ia.frame_start);
        fs_b += int'(ib.frame_start);
    endtask

    initial begin
        int hs_low, ls_cnt, t0, tick_low;
        // edges after reset release, expected x, y, flags {hv,vv,hs,vs,pt,ls,fs}
        va[0]  = '{0,    0,   0, 7'b1111000};
        va[1]  = '{1,    0,   0, 7'b1111000};
        va[2]  = '{2,    1,   0, 7'b1111100};
        va[3]  = '{3,    1,   0, 7'b1111000};
        va[4]  = '{1279, 639, 0, 7'b1111000};
        va[5]  = '{1280, 640, 0, 7'b0111100};
        va[6]  = '{1311, 655, 0, 7'b0111000};
        va[7]  = '{1312, 656, 0, 7'b0101100};
        va[8]  = '{1502, 751, 0, 7'b0101100};
        va[9]  = '{1504, 752, 0, 7'b0111100};
        va[10] = '{1598, 799, 0, 7'b0111100};
        va[11] = '{1600, 0,   1, 7'b1111110};
        va[12] = '{1601, 0,   1, 7'b1111000};
        vb[0]  = '{0,  0,  0, 7'b1111000};
        vb[1]  = '{1,  1,  0, 7'b1111100};
        vb[2]  = '{8,  8,  0, 7'b0111100};
        vb[3]  = '{9,  9,  0, 7'b0101100};
        vb[4]  = '{10, 10, 0, 7'b0101100};
        vb[5]  = '{11, 11, 0, 7'b0111100};
        vb[6]  = '{12, 0,  1, 7'b1111110};
        vb[7]  = '{48, 0,  4, 7'b1011110};
        vb[8]  = '{60, 0,  5, 7'b1010110};
        vb[9]  = '{71, 11, 5, 7'b0010100};
        vb[10] = '{72, 0,  6, 7'b1011110};
        vb[11] = '{83, 11, 6, 7'b0011100};
        vb[12] = '{84, 0,  0, 7'b1111111};
        vb[13] = '{85, 1,  0, 7'b1111100};

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a_n = 1'b1;
        cyc = 0;
        foreach (va[i]) begin
            while (cyc < va[i].n) step();
            check_vec("default_vec", va[i], int'(ia.pixel_x), int'(ia.pixel_y), flags_a());
        end

        while (cyc < 1700) begin
            step();
            check("tick_spacing", int'(ia.pixel_tick), int'(cyc % 2 == 0));
        end

        hs_low = 0;
        ls_cnt = 0;
        while (cyc < 3199) begin
            step();
            hs_low += int'(!ia.hsync);
            ls_cnt += int'(ia.line_start);
        end
        check("hsync_low_clks", hs_low, 192);
        check("line_start_midline", ls_cnt, 0);
        step();
        check("line2_start", int'(ia.line_start), 1);
        check("line2_y", int'(ia.pixel_y), 2);

        while (cyc < 4601) step();
        check_vec("pre_reset", '{4601, 700, 2, 7'b0101000}, int'(ia.pixel_x), int'(ia.pixel_y), flags_a());
        #2 rst_a_n = 1'b0;
        #1;
        check_vec("async_reset", '{0, 0, 0, 7'b1111000}, int'(ia.pixel_x), int'(ia.pixel_y), flags_a());
        @(negedge clk);
        rst_a_n = 1'b1;
        cyc = 0;
        step();
        check_vec("restart", '{1, 0, 0, 7'b1111000}, int'(ia.pixel_x), int'(ia.pixel_y), flags_a());
        step();
        check_vec("restart", '{2, 1, 0, 7'b1111100}, int'(ia.pixel_x), int'(ia.pixel_y), flags_a());
        check("no_frame_start_default", fs_a, 0);

        @(negedge clk);
        rst_b_n = 1'b1;
        cyc = 0;
        fs_b = 0;
        foreach (vb[i]) begin
            while (cyc < vb[i].n) step();
            check_vec("small_vec", vb[i], int'(ib.pixel_x), int'(ib.pixel_y), flags_b());
        end
        check("small_first_frame_pulses", fs_b, 1);

        t0 = cyc;
        tick_low = 0;
        ls_cnt = 0;
        do begin
            step();
            tick_low += int'(!ib.pixel_tick);
            ls_cnt += int'(ib.line_start);
        end while (!ib.frame_start && cyc - t0 < 200);
        check("small_frame_period", cyc - 84, 84);
        check("small_tick_low", tick_low, 0);
        check("small_lines_per_frame", ls_cnt, 7);
        check("small_frame_ls_fs", int'({ib.line_start, ib.frame_start}), 3);

        t0 = cyc;
        do step(); while (!ib.line_start && cyc - t0 < 50);
        check("small_line_period", cyc - t0, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
